roulette: RTL
=============

ROULETTE -- requirements
Module: roulette

Interface
REQ-001 Parameters SHALL be: BIT_WIDTH, default 32, photon word width; LAYER_WIDTH, default 3, layer index width; WEIGHT_LIM, default 32'h0006_8DB9, roulette threshold (0.0001 in unsigned Q0.32); CHANCE_LOG2, default 4, survival odds 1/2^CHANCE_LOG2; DEFAULT_SEED, default 32'h1234_5678, LFSR reset value.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset; ports SHALL be as follows (clock and reset first).
REQ-003 clock  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 enable  in  1  pipeline advance; low = hold all state.
REQ-006 x_hop, y_hop, z_hop, ux_hop, uy_hop, uz_hop, sz_hop, sr_hop, sleftz_hop, sleftr_hop  in  BIT_WIDTH each  photon fields from hop stage.
REQ-007 layer_hop  in  LAYER_WIDTH  layer index; weight_hop  in  BIT_WIDTH  unsigned photon weight; dead_hop  in  1  photon dead; hit_hop  in  1  boundary hit pending.
REQ-008 seed  in  32  LFSR seed; load_seed  in  1  one-cycle seed load strobe.
REQ-009 x_roulette ... sleftr_roulette, layer_roulette, weight_roulette, dead_roulette, hit_roulette  out  same widths as inputs  registered photon fields.
REQ-010 killed_count  out  32  photons killed by roulette; survived_count  out  32  photons surviving roulette.

Function
REQ-011 Latency SHALL be exactly one enabled clock; all outputs registered.
REQ-012 x, y, z, ux, uy, uz, sz, sr, sleftz, sleftr, layer, hit SHALL pass through unchanged.
REQ-013 Roulette candidate = !dead_hop && !hit_hop && weight_hop < WEIGHT_LIM.
REQ-014 Non-candidate: weight and dead pass through unchanged; no counter change.
REQ-015 Candidate with weight_hop == 0: dead=1, weight=0, killed_count +1, no LFSR draw consulted.
REQ-016 Candidate with weight_hop > 0: survive iff lfsr[CHANCE_LOG2-1:0] == 0; survive -> weight = weight_hop << CHANCE_LOG2, dead=0, survived_count +1; else dead=1, weight=0, killed_count +1.
REQ-017 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shift right, advances once per enabled cycle regardless of candidacy.
REQ-018 Decision SHALL use LFSR value before that cycle's advance.
REQ-019 load_seed=1 SHALL load seed into LFSR irrespective of enable; seed==0 loads 32'h0000_0001 (lockup guard).
REQ-020 load_seed with enable same cycle: photon uses pre-load LFSR value; load overrides advance.
REQ-021 Counters SHALL saturate at 32'hFFFF_FFFF, never wrap.
REQ-022 enable=0: outputs, counters, LFSR (except load_seed) hold.
REQ-023 WEIGHT_LIM << CHANCE_LOG2 SHALL be < 2^BIT_WIDTH (elaboration check); survivor shift never overflows.

Reset
REQ-024 Reset SHALL take priority over enable and load_seed.
REQ-025 On reset: all photon outputs 0, dead_roulette=1, hit_roulette=0, counters 0, LFSR=DEFAULT_SEED.
REQ-026 Reset mid-stream SHALL discard the in-flight photon; first post-reset decision uses DEFAULT_SEED.

Structure
REQ-027 Shared package SHALL hold BIT_WIDTH, LAYER_WIDTH, WEIGHT_LIM, CHANCE_LOG2, LFSR mask and DEFAULT_SEED.
REQ-028 LFSR SHALL be sub-module rng_lfsr32 (clock, reset, enable, load, seed, state); roulette logic and counters stay in roulette.

Verification
REQ-029 Reset, then enable=1, weight_hop=32'h0010_0000, dead=0, hit=0 -> next cycle weight_roulette=32'h0010_0000, dead=0, counters 0.
REQ-030 load_seed with seed=32'h0000_0010 (low nibble 0), weight_hop=32'h0000_1000 next cycle -> weight_roulette=32'h0001_0000, dead=0, survived_count=1.
REQ-031 load_seed seed=32'h0000_0003, weight_hop=32'h0000_1000 -> weight_roulette=0, dead_roulette=1, killed_count=1.
REQ-032 dead_hop=1 or hit_hop=1 with weight_hop=32'h0000_0005 -> outputs pass through, counters and weight unchanged.
REQ-033 10^6 candidates, seed=32'hACE1_ACE1 -> survived/total within 6.25% +/- 0.2%; counters forced near 32'hFFFF_FFFE saturate at 32'hFFFF_FFFF.
REQ-034 enable=0 for 5 cycles mid-stream then reset asserted with enable=1 -> outputs held during stall; after reset all outputs 0, dead=1, LFSR=DEFAULT_SEED.

Source files
------------

// File: rtl/roulette_pkg.sv
`default_nettype none
// ============================================================================
// Module      : roulette_pkg
// Description : Shared constants, decision type and helper functions for the
//               photon Russian-roulette stage and its LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
package roulette_pkg;

    localparam int          RLT_BIT_WIDTH    = 32;
    localparam int          RLT_LAYER_WIDTH  = 3;
    localparam logic [31:0] RLT_WEIGHT_LIM   = 32'h0006_8DB9;  // 0.0001 in unsigned Q0.32
    localparam int          RLT_CHANCE_LOG2  = 4;              // survival odds 1/16
    localparam logic [31:0] LFSR_MASK        = 32'h8020_0003;  // x^32+x^22+x^2+x+1
    localparam logic [31:0] RLT_DEFAULT_SEED = 32'h1234_5678;

    typedef enum logic [1:0] {
        DEC_PASS    = 2'd0,
        DEC_KILL    = 2'd1,
        DEC_SURVIVE = 2'd2
    } decision_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One right-shift step of the Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    // An all-zero state would lock the LFSR forever; substitute 1.
    function automatic logic [31:0] seed_guard(input logic [31:0] s);
        return (s == 32'h0) ? 32'h0000_0001 : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rng_lfsr32.sv
`default_nettype none
// ============================================================================
// Module      : rng_lfsr32
// Description : 32-bit Galois LFSR with seed load and advance enable. A seed
//               load wins over the advance in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rng_lfsr32
    import roulette_pkg::*;
#(
    parameter logic [31:0] SEED_RESET = RLT_DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Next state: load overrides advance; otherwise hold.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed_guard(seed);
        end else if (enable) begin
            state_d = lfsr_step(state_q);
        end
    end

    // State register with synchronous reset to the default seed.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEED_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/roulette.sv
`default_nettype none
// ============================================================================
// Module      : roulette
// Description : One-cycle photon Russian-roulette stage. Low-weight live
//               photons either die or survive with boosted weight, decided by
//               the LFSR value held before this cycle's advance.
// Revision    : 1.0 - initial release
// ============================================================================
module roulette
    import roulette_pkg::*;
#(
    parameter int                   BIT_WIDTH    = RLT_BIT_WIDTH,
    parameter int                   LAYER_WIDTH  = RLT_LAYER_WIDTH,
    parameter logic [BIT_WIDTH-1:0] WEIGHT_LIM   = BIT_WIDTH'(RLT_WEIGHT_LIM),
    parameter int                   CHANCE_LOG2  = RLT_CHANCE_LOG2,
    parameter logic [31:0]          DEFAULT_SEED = RLT_DEFAULT_SEED
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [BIT_WIDTH-1:0]   x_hop,
    input  logic [BIT_WIDTH-1:0]   y_hop,
    input  logic [BIT_WIDTH-1:0]   z_hop,
    input  logic [BIT_WIDTH-1:0]   ux_hop,
    input  logic [BIT_WIDTH-1:0]   uy_hop,
    input  logic [BIT_WIDTH-1:0]   uz_hop,
    input  logic [BIT_WIDTH-1:0]   sz_hop,
    input  logic [BIT_WIDTH-1:0]   sr_hop,
    input  logic [BIT_WIDTH-1:0]   sleftz_hop,
    input  logic [BIT_WIDTH-1:0]   sleftr_hop,
    input  logic [LAYER_WIDTH-1:0] layer_hop,
    input  logic [BIT_WIDTH-1:0]   weight_hop,
    input  logic                   dead_hop,
    input  logic                   hit_hop,
    input  logic [31:0]            seed,
    input  logic                   load_seed,
    output logic [BIT_WIDTH-1:0]   x_roulette,
    output logic [BIT_WIDTH-1:0]   y_roulette,
    output logic [BIT_WIDTH-1:0]   z_roulette,
    output logic [BIT_WIDTH-1:0]   ux_roulette,
    output logic [BIT_WIDTH-1:0]   uy_roulette,
    output logic [BIT_WIDTH-1:0]   uz_roulette,
    output logic [BIT_WIDTH-1:0]   sz_roulette,
    output logic [BIT_WIDTH-1:0]   sr_roulette,
    output logic [BIT_WIDTH-1:0]   sleftz_roulette,
    output logic [BIT_WIDTH-1:0]   sleftr_roulette,
    output logic [LAYER_WIDTH-1:0] layer_roulette,
    output logic [BIT_WIDTH-1:0]   weight_roulette,
    output logic                   dead_roulette,
    output logic                   hit_roulette,
    output logic [31:0]            killed_count,
    output logic [31:0]            survived_count
);

    // Survivor weight must never overflow the word after the boost shift.
    localparam logic [63:0] LIM_SHIFTED = 64'(WEIGHT_LIM) << CHANCE_LOG2;
    if (BIT_WIDTH < 64 && LIM_SHIFTED >= (64'd1 << BIT_WIDTH)) begin : g_lim_check
        $error("roulette: WEIGHT_LIM << CHANCE_LOG2 overflows BIT_WIDTH");
    end

    // Untouched fields travel together as one word.
    localparam int PASS_W = 10 * BIT_WIDTH + LAYER_WIDTH + 1;

    logic [PASS_W-1:0]    pass_q,     pass_d;
    logic [BIT_WIDTH-1:0] weight_q,   weight_d;
    logic                 dead_q,     dead_d;
    logic [31:0]          killed_count_q,   killed_count_d;
    logic [31:0]          survived_count_q, survived_count_d;
    logic [31:0]          lfsr_state;
    logic                 lfsr_unused;
    logic                 candidate;
    decision_e            decision;

    rng_lfsr32 #(
        .SEED_RESET (DEFAULT_SEED)
    ) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .load   (load_seed),
        .seed   (seed),
        .state  (lfsr_state)
    );

    // Only the low CHANCE_LOG2 bits act as the draw.
    assign lfsr_unused = ^lfsr_state[31:CHANCE_LOG2];

    // Classify the incoming photon from the pre-advance LFSR value.
    always_comb begin
        candidate = !dead_hop && !hit_hop && (weight_hop < WEIGHT_LIM);
        decision  = DEC_PASS;
        if (candidate) begin
            if (weight_hop == '0) begin
                decision = DEC_KILL;
            end else if (lfsr_state[CHANCE_LOG2-1:0] == '0) begin
                decision = DEC_SURVIVE;
            end else begin
                decision = DEC_KILL;
            end
        end
    end

    // Next-state for the photon register and counters; hold when stalled.
    always_comb begin
        pass_d           = pass_q;
        weight_d         = weight_q;
        dead_d           = dead_q;
        killed_count_d   = killed_count_q;
        survived_count_d = survived_count_q;
        if (enable) begin
            pass_d   = {x_hop, y_hop, z_hop, ux_hop, uy_hop, uz_hop, sz_hop, sr_hop,
                        sleftz_hop, sleftr_hop, layer_hop, hit_hop};
            weight_d = weight_hop;
            dead_d   = dead_hop;
            case (decision)
                DEC_KILL: begin
                    weight_d       = '0;
                    dead_d         = 1'b1;
                    killed_count_d = sat_inc32(killed_count_q);
                end
                DEC_SURVIVE: begin
                    weight_d         = weight_hop << CHANCE_LOG2;
                    dead_d           = 1'b0;
                    survived_count_d = sat_inc32(survived_count_q);
                end
                default: begin
                end
            endcase
        end
    end

    // Output and counter registers; reset leaves an empty, dead slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            pass_q           <= '0;
            weight_q         <= '0;
            dead_q           <= 1'b1;
            killed_count_q   <= '0;
            survived_count_q <= '0;
        end else begin
            pass_q           <= pass_d;
            weight_q         <= weight_d;
            dead_q           <= dead_d;
            killed_count_q   <= killed_count_d;
            survived_count_q <= survived_count_d;
        end
    end

    assign {x_roulette, y_roulette, z_roulette, ux_roulette, uy_roulette, uz_roulette,
            sz_roulette, sr_roulette, sleftz_roulette, sleftr_roulette,
            layer_roulette, hit_roulette} = pass_q;
    assign weight_roulette = weight_q;
    assign dead_roulette   = dead_q;
    assign killed_count    = killed_count_q;
    assign survived_count  = survived_count_q;

endmodule
`default_nettype wire
